// File: rtl/sample_slot_scheduler.sv
// Round-robin scheduler granting one fixed-length timed slot at a time to NREQ
// requesting channels; each normally completed slot ends with a one-cycle ack.
module sample_slot_scheduler #(
    parameter int NREQ = 4,
    parameter int NBIT = 16,
    parameter int MAX  = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [NREQ-1:0] ack,
    output logic            busy,
    output logic [NBIT-1:0] count
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_ACK} state_t;

    state_t          state, state_n;
    logic [NREQ-1:0] grant_n, ack_n;
    logic            busy_n;
    logic [NBIT-1:0] count_n;
    logic [PW-1:0]   ptr, ptr_n, win, win_n, pick;
    logic            found;
    int unsigned     idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            grant <= '0;
            ack   <= '0;
            busy  <= 1'b0;
            count <= '0;
            ptr   <= PW'(NREQ - 1);
            win   <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            ack   <= ack_n;
            busy  <= busy_n;
            count <= count_n;
            ptr   <= ptr_n;
            win   <= win_n;
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        ack_n   = '0;
        busy_n  = busy;
        count_n = count;
        ptr_n   = ptr;
        win_n   = win;
        pick    = '0;
        found   = 1'b0;
        idx     = 0;

        // Scan ptr+1 .. ptr+NREQ so the last served channel has lowest priority.
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end

        case (state)
            S_IDLE: begin
                if (en && found) begin
                    state_n       = S_RUN;
                    grant_n       = '0;
                    grant_n[pick] = 1'b1;
                    busy_n        = 1'b1;
                    count_n       = '0;
                    win_n         = pick;
                end
            end
            S_RUN: begin
                // Cancel wins over completion when both happen in the same cycle.
                if (!req[win]) begin
                    state_n = S_IDLE;
                    grant_n = '0;
                    busy_n  = 1'b0;
                    count_n = '0;
                    ptr_n   = win;
                end else if (count == NBIT'(MAX - 1)) begin
                    state_n    = S_ACK;
                    grant_n    = '0;
                    ack_n[win] = 1'b1;
                    busy_n     = 1'b0;
                    count_n    = '0;
                    ptr_n      = win;
                end else begin
                    count_n = count + NBIT'(1);
                end
            end
            S_ACK:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sample_slot_scheduler.sv
// Self-checking bench for sample_slot_scheduler (NREQ=4, MAX=4) with directed
// scenarios and a randomized run against a slot-level reference model.
module tb_sample_slot_scheduler;

    localparam int NREQ = 4;
    localparam int NBIT = 16;
    localparam int MAX  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            en  = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] grant, ack;
    logic            busy;
    logic [NBIT-1:0] count;

    int checks = 0;
    int errors = 0;

    // Reference model: channel in service (-1 none), cycles elapsed in slot,
    // channel being acknowledged (-1 none), last served channel.
    int m_cur, m_age, m_ack, m_ptr;

    sample_slot_scheduler #(.NREQ(NREQ), .NBIT(NBIT), .MAX(MAX)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .grant(grant), .ack(ack), .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_cur = -1; m_age = 0; m_ack = -1; m_ptr = NREQ - 1;
    endtask

    task automatic model_update();
        if (!rst) begin
            model_reset();
        end else if (m_cur >= 0) begin
            if (!req[m_cur]) begin
                m_ptr = m_cur; m_cur = -1; m_age = 0;
            end else if (m_age == MAX - 1) begin
                m_ptr = m_cur; m_ack = m_cur; m_cur = -1; m_age = 0;
            end else begin
                m_age++;
            end
        end else if (m_ack >= 0) begin
            m_ack = -1;
        end else if (en && req != 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (req[(m_ptr + k) % NREQ]) begin
                    m_cur = (m_ptr + k) % NREQ;
                    m_age = 0;
                    break;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; req = '0; en = 1'b1;
        model_reset();
        step(); step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 4'b1111; en = 1'b1;
        model_reset();
        step(); step(); step();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b want 0000", ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        rst = 1'b1;
        step();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b want 0001", grant); end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        for (int c = 1; c <= 4; c++) begin
            step();
            checks++; if (grant !== 4'b0100 || busy !== 1'b1) begin errors++; $display("FAIL single_grant c%0d got %b/%b want 0100/1", c, grant, busy); end
            checks++; if (count !== 16'(c - 1)) begin errors++; $display("FAIL single_count c%0d got %0d want %0d", c, count, c - 1); end
        end
        step();
        checks++; if (ack !== 4'b0100 || grant !== 4'b0000) begin errors++; $display("FAIL single_ack got ack %b grant %b want 0100/0000", ack, grant); end
        req = '0;
        step();
        checks++; if (ack !== 4'b0000 || grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_idle got ack %b grant %b busy %b", ack, grant, busy); end
    endtask

    task automatic test_round_robin();
        int n = 0, prev_on = 0, len = 0, ch;
        int exp_ch[5] = '{0, 1, 2, 3, 0};
        do_reset();
        req = 4'b1111;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            step();
            if (grant != 0) begin
                len++;
                if (len == 1) begin
                    ch = -1;
                    for (int b = 0; b < NREQ; b++) if (grant[b]) ch = b;
                    if (n < 5) begin
                        checks++; if (ch !== exp_ch[n]) begin errors++; $display("FAIL rr_order #%0d got ch%0d want ch%0d", n, ch, exp_ch[n]); end
                        checks++; if (cyc !== 1 + 6 * n) begin errors++; $display("FAIL rr_spacing #%0d got cycle %0d want %0d", n, cyc, 1 + 6 * n); end
                    end
                    n++;
                end
            end else if (len != 0) begin
                checks++; if (len !== MAX) begin errors++; $display("FAIL rr_length got %0d want %0d", len, MAX); end
                len = 0;
            end
            prev_on = (grant != 0);
        end
        checks++; if (n !== 5) begin errors++; $display("FAIL rr_count got %0d want 5", n); end
        req = '0;
    endtask

    task automatic test_cancel();
        do_reset();
        req = 4'b0010;
        step(); step(); step();
        checks++; if (grant !== 4'b0010 || count !== 16'd2) begin errors++; $display("FAIL cancel_setup got %b/%0d want 0010/2", grant, count); end
        req = 4'b1001;
        step();
        checks++; if (grant !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0 || count !== 16'd0) begin
            errors++; $display("FAIL cancel_drop got grant %b ack %b busy %b count %0d", grant, ack, busy, count); end
        step();
        checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL cancel_next got %b want 1000", grant); end
        req = '0;
        step();
    endtask

    task automatic test_enable();
        do_reset();
        en = 1'b0; req = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL en_hold got %b want 0000", grant); end
        end
        en = 1'b1;
        step();
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL en_raise got %b want 0010", grant); end
        step();
        en = 1'b0;
        step(); step();
        checks++; if (grant !== 4'b0010 || count !== 16'd3) begin errors++; $display("FAIL en_midslot got %b/%0d want 0010/3", grant, count); end
        step();
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL en_ack got %b want 0010", ack); end
        req = '0; en = 1'b1;
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0001;
        step(); step(); step();
        checks++; if (count !== 16'd2 || grant !== 4'b0001) begin errors++; $display("FAIL areset_setup got %b/%0d want 0001/2", grant, count); end
        #2 rst = 1'b0;
        model_reset();
        #1;
        checks++; if (grant !== 4'b0000 || busy !== 1'b0 || count !== 16'd0 || ack !== 4'b0000) begin
            errors++; $display("FAIL areset_clear got grant %b busy %b count %0d ack %b", grant, busy, count, ack); end
        step(); step();
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL areset_noack got %b want 0000", ack); end
        rst = 1'b1; req = '0;
        step();
    endtask

    task automatic test_random();
        logic [NREQ-1:0] eg, ea;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) req = NREQ'($urandom_range(0, 15));
            if (ack != 0 && $urandom_range(0, 1) == 1) req = req & ~ack;
            en = ($urandom_range(0, 7) != 0);
            step();
            eg = '0; ea = '0;
            if (m_cur >= 0) eg[m_cur] = 1'b1;
            if (m_ack >= 0) ea[m_ack] = 1'b1;
            checks++; if (grant !== eg) begin errors++; $display("FAIL rand_grant c%0d got %b want %b", c, grant, eg); end
            checks++; if (ack !== ea) begin errors++; $display("FAIL rand_ack c%0d got %b want %b", c, ack, ea); end
            checks++; if (busy !== (m_cur >= 0)) begin errors++; $display("FAIL rand_busy c%0d got %b want %b", c, busy, m_cur >= 0); end
            checks++; if (count !== 16'((m_cur >= 0) ? m_age : 0)) begin errors++; $display("FAIL rand_count c%0d got %0d want %0d", c, count, (m_cur >= 0) ? m_age : 0); end
        end
        req = '0; en = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_cancel();
        test_enable();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
